// File: rtl/vec_mul_sequencer_if.sv
// Job-request and datapath-strobe bundle shared by the vector-multiply sequencer and its host.
// The sequencer takes the slave side; the host/datapath environment takes the master side.
interface vec_mul_sequencer_if #(
    parameter int ADDRESSSIZE = 10,
    parameter int WSEL_BW     = 2
);
    logic                   start;
    logic                   abort;
    logic [ADDRESSSIZE-1:0] src_base;
    logic [ADDRESSSIZE-1:0] dst_base;
    logic [ADDRESSSIZE-1:0] vec_count;
    logic [WSEL_BW-1:0]     weight_sel;
    logic [WSEL_BW-1:0]     weight_addr;
    logic                   weight_reload;
    logic [ADDRESSSIZE-1:0] ub_addr;
    logic                   ub_rd_valid;
    logic                   res_we;
    logic [ADDRESSSIZE-1:0] res_addr;
    logic                   busy;
    logic                   done;

    modport master (
        output start, abort, src_base, dst_base, vec_count, weight_sel,
        input  weight_addr, weight_reload, ub_addr, ub_rd_valid,
               res_we, res_addr, busy, done
    );

    modport slave (
        input  start, abort, src_base, dst_base, vec_count, weight_sel,
        output weight_addr, weight_reload, ub_addr, ub_rd_valid,
               res_we, res_addr, busy, done
    );
endinterface

// File: rtl/vec_mul_sequencer.sv
// Single-FSM job sequencer for the vector-multiply datapath: weight load, input streaming,
// and result write-back through a valid shift register matched to the datapath latency.
//
// state  | meaning
// IDLE   | waiting for start; strobes low
// WLOAD  | weight_reload held while the selected tile shifts into the array
// STREAM | one unified-buffer read issued per cycle
// DRAIN  | waiting for the last in-flight result to be written
// DONE   | one-cycle done pulse
module vec_mul_sequencer #(
    parameter int ADDRESSSIZE  = 10,
    parameter int WSEL_BW      = 2,
    parameter int WLOAD_CYCLES = 16,
    parameter int PIPE_LATENCY = 17
) (
    input logic               clk,
    input logic               rstn,
    vec_mul_sequencer_if.slave bus
);
    localparam int WCNT_BW = $clog2(WLOAD_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WLOAD, STREAM, DRAIN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [WCNT_BW-1:0]     wload_cnt;
    logic [ADDRESSSIZE-1:0] issue_rem;
    logic [ADDRESSSIZE-1:0] src_ptr;
    logic [ADDRESSSIZE-1:0] dst_ptr;
    logic [PIPE_LATENCY-1:0] vpipe;
    logic [PIPE_LATENCY-1:0] vshift;
    logic                   we_nxt;
    logic                   pipe_empty_nxt;

    logic [WSEL_BW-1:0]     weight_addr_q;
    logic                   weight_reload_q;
    logic [ADDRESSSIZE-1:0] ub_addr_q;
    logic                   ub_rd_valid_q;
    logic [ADDRESSSIZE-1:0] res_addr_q;
    logic                   busy_q;
    logic                   done_q;

    // Next contents of the valid pipe; its top bit is next cycle's res_we.
    assign vshift         = PIPE_LATENCY'({vpipe, ub_rd_valid_q});
    assign we_nxt         = vshift[PIPE_LATENCY-1];
    assign pipe_empty_nxt = (vshift == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.vec_count == '0) state_nxt = DONE;
                    else                     state_nxt = WLOAD;
                end
            end
            WLOAD:   if (wload_cnt == '0) state_nxt = STREAM;
            STREAM:  if (issue_rem == ADDRESSSIZE'(1)) state_nxt = DRAIN;
            DRAIN:   if (pipe_empty_nxt) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && bus.abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wload_cnt       <= '0;
            issue_rem       <= '0;
            src_ptr         <= '0;
            dst_ptr         <= '0;
            vpipe           <= '0;
            weight_addr_q   <= '0;
            weight_reload_q <= 1'b0;
            ub_addr_q       <= '0;
            ub_rd_valid_q   <= 1'b0;
            res_addr_q      <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            weight_reload_q <= (state_nxt == WLOAD);
            ub_rd_valid_q   <= (state_nxt == STREAM);
            busy_q          <= (state_nxt != IDLE);
            done_q          <= (state_nxt == DONE);
            vpipe           <= (state_nxt == IDLE) ? '0 : vshift;

            if (state == IDLE && state_nxt == WLOAD) begin
                wload_cnt     <= WCNT_BW'(WLOAD_CYCLES - 1);
                issue_rem     <= bus.vec_count;
                src_ptr       <= bus.src_base;
                dst_ptr       <= bus.dst_base;
                weight_addr_q <= bus.weight_sel;
            end else if (state_nxt == IDLE) begin
                wload_cnt <= '0;
                issue_rem <= '0;
                src_ptr   <= '0;
                dst_ptr   <= '0;
            end else begin
                if (state == WLOAD && wload_cnt != '0)
                    wload_cnt <= wload_cnt - WCNT_BW'(1);
                if (state == STREAM)
                    issue_rem <= issue_rem - ADDRESSSIZE'(1);
                if (state_nxt == STREAM) begin
                    ub_addr_q <= src_ptr;
                    src_ptr   <= src_ptr + ADDRESSSIZE'(1);
                end
                // The write pointer only moves when a result actually lands.
                if (we_nxt) begin
                    res_addr_q <= dst_ptr;
                    dst_ptr    <= dst_ptr + ADDRESSSIZE'(1);
                end
            end
        end
    end

    assign bus.weight_addr   = weight_addr_q;
    assign bus.weight_reload = weight_reload_q;
    assign bus.ub_addr       = ub_addr_q;
    assign bus.ub_rd_valid   = ub_rd_valid_q;
    assign bus.res_we        = vpipe[PIPE_LATENCY-1];
    assign bus.res_addr      = res_addr_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Bench for vec_mul_sequencer: per-cycle comparison against a timing-window model of each job.
module tb_vec_mul_sequencer;
    localparam int AW = 10;
    localparam int WB = 2;
    localparam int W  = 16;
    localparam int L  = 17;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    vec_mul_sequencer_if #(.ADDRESSSIZE(AW), .WSEL_BW(WB)) bus ();

    vec_mul_sequencer #(
        .ADDRESSSIZE(AW), .WSEL_BW(WB), .WLOAD_CYCLES(W), .PIPE_LATENCY(L)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          wrl;
        logic [WB-1:0] wa;
        logic          ubv;
        logic [AW-1:0] uba;
        logic          we;
        logic [AW-1:0] ra;
    } obs_t;

    // Expected outputs in cycle c of a job started in cycle 0, from the published timing windows.
    function automatic obs_t model(input int c, input int n, input int src, input int dst,
                                   input int sel, input int abort_at);
        obs_t e;
        int   fin;
        e   = '0;
        fin = (n == 0) ? 1 : W + n + L + 1;
        if (abort_at >= 0 && c > abort_at) return e;
        e.busy = (c >= 1 && c <= fin);
        e.done = (c >= 1 && c == fin);
        if (n > 0) begin
            e.wrl = (c >= 1 && c <= W);
            if (e.wrl) e.wa = sel[WB-1:0];
            e.ubv = (c >= W + 1 && c <= W + n);
            if (e.ubv) e.uba = AW'(src + (c - W - 1));
            e.we = (c >= W + 1 + L && c <= W + n + L);
            if (e.we) e.ra = AW'(dst + (c - W - 1 - L));
        end
        return e;
    endfunction

    // Addresses are only meaningful while their strobe is high.
    function automatic obs_t sample(input bit mask);
        obs_t a;
        a.busy = bus.busy;
        a.done = bus.done;
        a.wrl  = bus.weight_reload;
        a.wa   = bus.weight_addr;
        a.ubv  = bus.ub_rd_valid;
        a.uba  = bus.ub_addr;
        a.we   = bus.res_we;
        a.ra   = bus.res_addr;
        if (mask) begin
            if (!a.wrl) a.wa  = '0;
            if (!a.ubv) a.uba = '0;
            if (!a.we)  a.ra  = '0;
        end
        return a;
    endfunction

    // Entered and left just after a rising edge; cycle 0 is the cycle in which start is driven.
    task automatic run_job(input string name, input int src, input int dst, input int n,
                           input int sel, input int abort_at, input int extra_start_at,
                           input int rst_at, input bit abort_c0);
        obs_t e, a;
        int   fin, nwr, ndone, exp_wr, exp_done;
        bit   stop;
        fin   = (n == 0) ? 1 : W + n + L + 1;
        nwr   = 0;
        ndone = 0;
        stop  = 1'b0;

        bus.start      = 1'b1;
        bus.abort      = abort_c0;
        bus.src_base   = AW'(src);
        bus.dst_base   = AW'(dst);
        bus.vec_count  = AW'(n);
        bus.weight_sel = WB'(sel);
        @(negedge clk);
        e = model(0, n, src, dst, sel, abort_at);
        a = sample(1'b1);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s idle_c0 got %h expected %h", name, a, e);
        end
        @(posedge clk);
        #1;
        bus.src_base   = AW'($urandom);
        bus.dst_base   = AW'($urandom);
        bus.vec_count  = AW'($urandom);
        bus.weight_sel = WB'($urandom);

        for (int c = 1; c <= fin && !stop; c++) begin
            bus.abort = (c == abort_at);
            bus.start = (c == extra_start_at);
            if (c == rst_at) begin
                #2;
                rstn = 1'b0;
                #1;
                a = sample(1'b0);
                checks++;
                if (a !== '0) begin
                    errors++;
                    $display("FAIL %s async_reset c=%0d got %h expected 0", name, c, a);
                end
                @(posedge clk);
                #1;
                rstn = 1'b1;
                stop = 1'b1;
            end else begin
                @(negedge clk);
                e = model(c, n, src, dst, sel, abort_at);
                a = sample(1'b1);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s cycle c=%0d got busy=%b done=%b wrl=%b wa=%h ubv=%b uba=%h we=%b ra=%h expected busy=%b done=%b wrl=%b wa=%h ubv=%b uba=%h we=%b ra=%h",
                             name, c, a.busy, a.done, a.wrl, a.wa, a.ubv, a.uba, a.we, a.ra,
                             e.busy, e.done, e.wrl, e.wa, e.ubv, e.uba, e.we, e.ra);
                end
                nwr   += int'(a.we);
                ndone += int'(a.done);
                @(posedge clk);
                #1;
            end
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;

        if (rst_at < 0) begin
            exp_wr = 0;
            for (int k = 0; k < n; k++)
                if (abort_at < 0 || W + 1 + k + L <= abort_at) exp_wr++;
            exp_done = (abort_at < 0 || abort_at >= fin) ? 1 : 0;
            checks++;
            if (nwr !== exp_wr) begin
                errors++;
                $display("FAIL %s write_count got %0d expected %0d", name, nwr, exp_wr);
            end
            checks++;
            if (ndone !== exp_done) begin
                errors++;
                $display("FAIL %s done_count got %0d expected %0d", name, ndone, exp_done);
            end
        end
    endtask

    task automatic test_reset();
        obs_t a;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = sample(1'b0);
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", a);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_defaults();
        run_job("defaults", 'h010, 'h200, 4, 2, -1, -1, -1, 1'b0);
    endtask

    task automatic test_wrap();
        run_job("wrap", 'h3FE, 'h3FF, 3, 1, -1, -1, -1, 1'b0);
    endtask

    task automatic test_zero_count();
        run_job("zero_count", 'h055, 'h0AA, 0, 3, -1, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_job("b2b_zero", 'h100, 'h300, 0, 1, -1, -1, -1, 1'b0);
        run_job("b2b_one", 'h101, 'h301, 1, 0, -1, -1, -1, 1'b0);
        run_job("b2b_two", 'h3FF, 'h000, 2, 3, -1, -1, -1, 1'b0);
    endtask

    task automatic test_abort();
        run_job("abort_n8", 'h020, 'h120, 8, 1, 18, -1, -1, 1'b0);
        run_job("after_abort", 'h040, 'h140, 1, 2, -1, -1, -1, 1'b0);
        run_job("abort_drain", 'h060, 'h160, 5, 3, W + 5 + 8, -1, -1, 1'b0);
    endtask

    task automatic test_start_during_stream();
        run_job("start_in_stream", 'h080, 'h180, 6, 0, -1, W + 3, -1, 1'b0);
    endtask

    task automatic test_random();
        int n, fin, ab;
        for (int i = 0; i < 10; i++) begin
            n   = $urandom_range(1, 24);
            fin = W + n + L + 1;
            ab  = (i % 3 == 2) ? int'($urandom_range(1, fin)) : -1;
            run_job("random", int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    n, int'($urandom_range(0, 3)), ab, -1, -1, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_drain();
        run_job("reset_drain", 'h010, 'h200, 4, 2, -1, -1, W + 4 + 5, 1'b0);
        run_job("after_reset", 'h010, 'h200, 4, 2, -1, -1, -1, 1'b0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.src_base   = '0;
        bus.dst_base   = '0;
        bus.vec_count  = '0;
        bus.weight_sel = '0;
        test_reset();
        test_defaults();
        test_wrap();
        test_zero_count();
        test_back_to_back();
        test_abort();
        test_start_during_stream();
        test_random();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_mul_sequencer.md
# vec_mul_sequencer

Control sequencer for the 16x16 vector-multiply datapath: unified-buffer SRAM, weight SRAM, `vec_mul_1x64` array and results SRAM. One `start` runs a complete job: load one weight tile into the array, stream a contiguous run of input vectors from the unified buffer, and write each result vector to the results SRAM at a matching offset. It replaces free-running counter/valid-delay glue with one FSM that owns every datapath strobe and reports `busy`/`done`.

## Interface
- `ADDRESSSIZE`, 10: address width of the unified-buffer and results SRAMs.
- `WSEL_BW`, 2: weight-SRAM address width (number of tiles = 2^WSEL_BW).
- `WLOAD_CYCLES`, 16: cycles `weight_reload` is held so a tile shifts fully into the array.
- `PIPE_LATENCY`, 17: cycles from a `ub_addr` issue to its result at the results-SRAM input (SRAM read + array depth). Must be >= 1.

Ports:
- `clk` input 1: single clock. All logic is rising-edge.
- `rstn` input 1: reset, asynchronous and active-low.
- `start` input 1: job request, sampled only in IDLE.
- `abort` input 1: synchronous cancel, honoured in any non-IDLE state.
- `src_base` input ADDRESSSIZE: first unified-buffer address, latched at start.
- `dst_base` input ADDRESSSIZE: first results-SRAM address, latched at start.
- `vec_count` input ADDRESSSIZE: number of vectors, latched at start.
- `weight_sel` input WSEL_BW: weight tile, latched at start.
- `weight_addr` output WSEL_BW: weight-SRAM address.
- `weight_reload` output 1: array weight-load strobe.
- `ub_addr` output ADDRESSSIZE: unified-buffer read address.
- `ub_rd_valid` output 1: `ub_addr` carries a live vector this cycle.
- `res_we` output 1: results-SRAM write enable.
- `res_addr` output ADDRESSSIZE: results-SRAM write address.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.

## Operation
- The FSM has five states: IDLE, WLOAD, STREAM, DRAIN, DONE.
- IDLE, `start` high, `vec_count`!=0: latch all job inputs and go to WLOAD.
- IDLE, `start` high, `vec_count`==0: go to DONE. No datapath strobes are asserted.
- WLOAD: `weight_reload`=1 and `weight_addr`=latched `weight_sel` for exactly WLOAD_CYCLES cycles, then go to STREAM.
- STREAM: issue k (k=0..N-1) drives `ub_addr`=src_base+k and `ub_rd_valid`=1. After issue N-1, go to DRAIN.
- Valid pipeline: a PIPE_LATENCY-deep shift register carries `ub_rd_valid` and drives `res_we`. Write j drives `res_addr`=dst_base+j, using a write counter that advances only on `res_we`.
- DRAIN: wait until the shift register is empty, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDRESSSIZE, so `src_base`+k and `dst_base`+j wrap past all-ones to 0.
- `start` while `busy` is ignored and is not queued.
- `abort` has priority over every other transition. The next state is IDLE, the shift register and counters clear, and `done` does not pulse. Results already written stay in SRAM.
- `abort` and `start` high in the same IDLE cycle: `start` wins, because `abort` is ignored in IDLE.
- Reset: state=IDLE. Every output is 0, including `weight_addr`, `ub_addr` and `res_addr`. The shift register is cleared.
- Reset mid-job: the job is dropped immediately, with the same effect as abort.
- All outputs are registered. Outside an active phase, addresses hold their last value and strobes are 0.

## Timing
- Cycle 0 is the IDLE cycle in which `start` is sampled. W=WLOAD_CYCLES, N=vec_count, L=PIPE_LATENCY.
- `busy` is high from cycle 1 through cycle W+N+L+1 inclusive.
- `weight_reload` is high in cycles 1..W.
- `ub_rd_valid` is high in cycles W+1..W+N. Issue k occurs in cycle W+1+k.
- `res_we` for write k occurs in cycle W+1+k+L, with `res_addr`=dst_base+k.
- `done` pulses in cycle W+N+L+1. A new `start` is accepted from cycle W+N+L+2.
- Zero-count job: `done` pulses in cycle 1, and a new `start` is accepted in cycle 2.
- `abort` sampled in cycle c: cycle c+1 is IDLE with all strobes 0.
- No back-pressure: writes are unconditional, one per issued vector, in issue order.

## Test plan
- Defaults, src=0x010, dst=0x200, N=4, sel=2 -> `weight_reload` high in cycles 1-16 with `weight_addr`=2; `ub_addr` 0x010-0x013 in cycles 17-20; `res_we` in cycles 34-37 with `res_addr` 0x200-0x203; `done` in cycle 38.
- Wrap: src=0x3FE, dst=0x3FF, N=3 -> `ub_addr` sequence 0x3FE, 0x3FF, 0x000; `res_addr` sequence 0x3FF, 0x000, 0x001.
- N=0 -> `done` in cycle 1; `busy` high only in cycle 1; no `weight_reload`, `ub_rd_valid` or `res_we`.
- Abort in cycle 18 of an N=8 job -> cycle 19 is IDLE; no further `res_we`; `done` never pulses. A new start with N=1 then completes with `done` at 16+1+17+1=35 cycles after its start.
- `start` pulsed during STREAM -> ignored; exactly N writes occur and there is a single `done`.
- `rstn` low asynchronously mid-DRAIN -> all outputs 0 at once. After release, a new job runs to the nominal cycle counts.
